memory_dumper: RTL and testbench
================================

# memory_dumper

Reads back the program memory filled by the UART programmer and streams it out as UART bytes, two nibbles per byte, lowest address first. Sits between the CPU program memory read port and the UART transmitter. A dump is started by a one-cycle pulse and covers the whole address space. Used for host-side verification of a programmed image.

## Interface

Parameters:
- UART_DATA_LENGTH, 8, UART byte width; must equal 2*REGISTER_WIDTH.
- REGISTER_WIDTH, 4, memory word (nibble) width.
- MEMORY_ADDRESS_WIDTH, 4, memory address width; the dump covers 2^MEMORY_ADDRESS_WIDTH words, so 2^(MEMORY_ADDRESS_WIDTH-1) data bytes.

Ports:
- clk_i  input  1  single system clock; all logic is on the rising edge.
- reset_i  input  1  asynchronous, active-high reset.
- start_strb_i  input  1  one-cycle pulse; starts a dump when the block is idle.
- mem_data_i  input  REGISTER_WIDTH  memory read data, valid one cycle after a read request.
- addr_o  output  MEMORY_ADDRESS_WIDTH  memory read address.
- enable_read_memory_o  output  1  memory read request, one cycle per word.
- uart_busy_i  input  1  transmitter busy; goes high the cycle after a strobe and stays high until the byte is sent.
- uart_data_o  output  UART_DATA_LENGTH  byte to transmit.
- data_valid_strb_o  output  1  one-cycle strobe: uart_data_o is valid and must be sent.
- busy_o  output  1  high from the cycle after an accepted start until done.
- done_strb_o  output  1  one-cycle pulse after the last byte's transmission completes.

## Operation

- States: IDLE, RD_EVEN, RD_ODD, CAPTURE, SEND, GUARD, WAIT_TX, DONE.
- IDLE: if start_strb_i = 1, go to RD_EVEN with the pair counter at 0. While the block is not idle, start_strb_i is ignored.
- RD_EVEN: drive addr_o = 2*pair and enable_read_memory_o = 1. Go to RD_ODD.
- RD_ODD: capture mem_data_i into the high nibble of the byte register. Drive addr_o = 2*pair+1 and enable_read_memory_o = 1. Go to CAPTURE.
- CAPTURE: capture mem_data_i into the low nibble. Go to SEND.
- Packing rule: uart_data_o[7:4] = mem[even address] and uart_data_o[3:0] = mem[odd address].
- SEND: when uart_busy_i = 0, assert data_valid_strb_o for one cycle and go to GUARD. Otherwise hold in SEND.
- GUARD: one cycle with uart_busy_i ignored, to cover the transmitter's busy rise latency. Go to WAIT_TX.
- WAIT_TX: when uart_busy_i = 0, take one of two paths:
  - If the pair is not the last one, increment the pair counter and go to RD_EVEN.
  - Otherwise go to DONE.
- DONE: assert done_strb_o for one cycle and go to IDLE.
- Pair counter width is MEMORY_ADDRESS_WIDTH-1. The last pair is all ones. The counter does not wrap; it is cleared only on start.
- enable_read_memory_o is low in every state other than RD_EVEN and RD_ODD. addr_o holds its last value in those states.

## Timing

- Reset values: addr_o = 0, enable_read_memory_o = 0, uart_data_o = 0, data_valid_strb_o = 0, busy_o = 0, done_strb_o = 0, state IDLE.
- All outputs are registered.
- Start pulse in cycle 0 gives RD_EVEN in cycle 1. With the transmitter idle, the first data_valid_strb_o is in cycle 4.
- With a transmitter busy for B cycles, the byte period is B+5 cycles.
- uart_data_o is stable from its strobe until the next capture.
- Reset mid-dump: everything returns immediately to its reset values and no further strobes occur. A new start restarts at address 0.
- A start pulse coinciding with DONE is ignored.

## Configuration

- Macro DUMPER_CHECKSUM_EN.
- When defined: after the last data byte, one extra byte is sent before DONE. It is the XOR of all data bytes in the dump, using the same SEND/GUARD/WAIT_TX handshake. The checksum register clears on start.
- When undefined: exactly 2^(MEMORY_ADDRESS_WIDTH-1) bytes are sent, with no checksum logic.

## Test plan

- **Basic dump.** Memory word n = n (0..15), transmitter model busy for 20 cycles, start pulse.
  - Expect bytes 0x01, 0x23, 0x45, 0x67, 0x89, 0xAB, 0xCD, 0xEF.
  - With DUMPER_CHECKSUM_EN, expect an extra 0x00. Expect one done_strb_o.
- **Read port.** Check addr_o and enable_read_memory_o.
  - Expect the sequence 0..15, two read cycles per byte, and read enable never asserted outside RD_EVEN/RD_ODD.
- **Handshake.** Hold uart_busy_i high for 50 cycles at the first SEND.
  - Expect no strobe until busy falls, then exactly one strobe.
  - Expect uart_data_o = 0x01 throughout.
- **Ignored start.** Pulse start_strb_i mid-dump.
  - Expect the sequence unchanged: 8 bytes (9 with checksum) and a single done.
- **Reset mid-dump.** Assert reset_i after the third strobe.
  - Expect all outputs at 0 asynchronously.
  - Restart and expect the first byte 0x01 again.
- **Checksum** (macro defined). All memory = 0xD, 0x2 alternating.
  - Expect eight bytes 0xD2, then a checksum byte of 0x00.
  - With words 0..15, expect checksum 0x00; with all 0xF except word 0 = 0xE, expect 0x10.

Source files
------------

// File: rtl/memory_dumper.sv
// memory_dumper: reads the program memory pairwise and streams each nibble pair out as one UART byte.
// Define DUMPER_CHECKSUM_EN to append an XOR checksum byte after the last data byte.
module memory_dumper #(
  parameter int UART_DATA_LENGTH     = 8,
  parameter int REGISTER_WIDTH       = 4,
  parameter int MEMORY_ADDRESS_WIDTH = 4
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic                            start_strb_i,
  input  logic [REGISTER_WIDTH-1:0]       mem_data_i,
  output logic [MEMORY_ADDRESS_WIDTH-1:0] addr_o,
  output logic                            enable_read_memory_o,
  input  logic                            uart_busy_i,
  output logic [UART_DATA_LENGTH-1:0]     uart_data_o,
  output logic                            data_valid_strb_o,
  output logic                            busy_o,
  output logic                            done_strb_o
);
  localparam int PW = MEMORY_ADDRESS_WIDTH - 1;

  typedef enum logic [2:0] {
    IDLE, RD_EVEN, RD_ODD, CAPTURE, SEND, GUARD, WAIT_TX, DONE
  } state_t;

  state_t                            state_q, state_d;
  logic [PW-1:0]                     pair_q, pair_d;
  logic [MEMORY_ADDRESS_WIDTH-1:0]   addr_q, addr_d;
  logic                              en_q, en_d;
  logic [UART_DATA_LENGTH-1:0]       data_q, data_d;
  logic                              strb_q, strb_d;
  logic                              busy_q, busy_d;
  logic                              done_q, done_d;
`ifdef DUMPER_CHECKSUM_EN
  logic [UART_DATA_LENGTH-1:0]       csum_q, csum_d;
  logic                              csum_phase_q, csum_phase_d;
`endif

  always_comb begin
    state_d = state_q;
    pair_d  = pair_q;
    data_d  = data_q;
    addr_d  = addr_q;
`ifdef DUMPER_CHECKSUM_EN
    csum_d       = csum_q;
    csum_phase_d = csum_phase_q;
`endif
    case (state_q)
      IDLE: if (start_strb_i) begin
        state_d = RD_EVEN;
        pair_d  = '0;
`ifdef DUMPER_CHECKSUM_EN
        csum_d       = '0;
        csum_phase_d = 1'b0;
`endif
      end
      RD_EVEN: state_d = RD_ODD;
      RD_ODD: begin
        data_d[UART_DATA_LENGTH-1 -: REGISTER_WIDTH] = mem_data_i;
        state_d = CAPTURE;
      end
      CAPTURE: begin
        data_d[REGISTER_WIDTH-1:0] = mem_data_i;
        state_d = SEND;
      end
      SEND:    if (strb_q) state_d = GUARD;
      GUARD:   state_d = WAIT_TX;
      WAIT_TX: if (!uart_busy_i) begin
        if (pair_q != '1) begin
          pair_d  = pair_q + 1'b1;
          state_d = RD_EVEN;
        end
`ifdef DUMPER_CHECKSUM_EN
        else if (!csum_phase_q) begin
          csum_phase_d = 1'b1;
          data_d       = csum_q;
          state_d      = SEND;
        end
`endif
        else state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

`ifdef DUMPER_CHECKSUM_EN
    if (strb_q && !csum_phase_q) csum_d = csum_q ^ data_q;
`endif

    // The strobe register looks one cycle ahead so it is high in the SEND cycle it belongs to.
    strb_d = (state_d == SEND) && !strb_q && !uart_busy_i;
    en_d   = (state_d == RD_EVEN) || (state_d == RD_ODD);
    if (state_d == RD_EVEN)     addr_d = {pair_d, 1'b0};
    else if (state_d == RD_ODD) addr_d = {pair_q, 1'b1};
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      pair_q  <= '0;
      addr_q  <= '0;
      en_q    <= 1'b0;
      data_q  <= '0;
      strb_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef DUMPER_CHECKSUM_EN
      csum_q       <= '0;
      csum_phase_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pair_q  <= pair_d;
      addr_q  <= addr_d;
      en_q    <= en_d;
      data_q  <= data_d;
      strb_q  <= strb_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef DUMPER_CHECKSUM_EN
      csum_q       <= csum_d;
      csum_phase_q <= csum_phase_d;
`endif
    end
  end

  assign addr_o               = addr_q;
  assign enable_read_memory_o = en_q;
  assign uart_data_o          = data_q;
  assign data_valid_strb_o    = strb_q;
  assign busy_o               = busy_q;
  assign done_strb_o          = done_q;
endmodule

// File: tb/tb_memory_dumper.sv
// Randomised bench for memory_dumper: memory and transmitter models plus a byte-stream reference model.
module tb_memory_dumper;
  localparam int NB = 8;
`ifdef DUMPER_CHECKSUM_EN
  localparam int NBYTES = NB + 1;
`else
  localparam int NBYTES = NB;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] mem_data = '0;
  logic [3:0] addr_o;
  logic       enable_read_memory_o;
  logic       uart_busy_i;
  logic [7:0] uart_data_o;
  logic       data_valid_strb_o;
  logic       busy_o;
  logic       done_strb_o;

  int checks = 0, errors = 0;
  int cyc = 0, start_cyc = 0, last_strb = 0;
  int rd_idx = 0, nstrb = 0, ndone = 0;
  int tx_b = 20, tx_cnt = 0;
  bit timed = 1'b0, hold = 1'b0;
  logic [3:0] mem [16];
  logic [7:0] got [16];
  logic [7:0] exp_q [$];

  memory_dumper dut (
    .clk_i(clk), .reset_i(rst), .start_strb_i(start), .mem_data_i(mem_data),
    .addr_o(addr_o), .enable_read_memory_o(enable_read_memory_o),
    .uart_busy_i(uart_busy_i), .uart_data_o(uart_data_o),
    .data_valid_strb_o(data_valid_strb_o), .busy_o(busy_o), .done_strb_o(done_strb_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous memory: data appears the cycle after the request.
  always @(posedge clk) if (enable_read_memory_o) mem_data <= mem[addr_o];

  // Transmitter: busy for tx_b cycles starting the cycle after a strobe.
  always @(posedge clk) begin
    if (data_valid_strb_o) tx_cnt <= tx_b;
    else if (tx_cnt != 0)  tx_cnt <= tx_cnt - 1;
  end
  assign uart_busy_i = (tx_cnt != 0) || hold;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (enable_read_memory_o) begin
        chk("rd_addr", addr_o, rd_idx);
        rd_idx++;
      end
      if (data_valid_strb_o) begin
        chk("strb_tx_idle", uart_busy_i, 0);
        chk("strb_busy_o", busy_o, 1);
        if (exp_q.size() == 0) chk("strobe_count", nstrb + 1, NBYTES);
        else                   chk("byte", uart_data_o, exp_q.pop_front());
        if (nstrb < 16) got[nstrb] = uart_data_o;
        if (nstrb < NB) chk("reads_before_byte", rd_idx, 2 * (nstrb + 1));
        if (timed) begin
          if (nstrb == 0)     chk("first_latency", cyc - start_cyc, 4);
          else if (nstrb < NB) chk("byte_period", cyc - last_strb, tx_b + 5);
        end
        last_strb = cyc;
        nstrb++;
      end
      if (done_strb_o) begin
        chk("done_pending", exp_q.size(), 0);
        chk("done_reads", rd_idx, 16);
        ndone++;
      end
      if (!busy_o) chk("idle_quiet", {enable_read_memory_o, data_valid_strb_o, done_strb_o}, 0);
    end
  end

  // Reference model: the expected byte stream follows directly from the memory image.
  task automatic start_dump(input bit t);
    logic [7:0] b, cs;
    exp_q.delete();
    cs = '0;
    for (int p = 0; p < NB; p++) begin
      b = {mem[2*p], mem[2*p+1]};
      exp_q.push_back(b);
      cs ^= b;
    end
`ifdef DUMPER_CHECKSUM_EN
    exp_q.push_back(cs);
`endif
    rd_idx = 0; nstrb = 0; ndone = 0; timed = t;
    start_cyc = cyc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int k = 0;
    while (ndone == 0 && k < 3000) begin @(negedge clk); k++; end
    repeat (3) @(negedge clk);
    chk({nm, "_done"}, ndone, 1);
    chk({nm, "_bytes"}, nstrb, NBYTES);
    chk({nm, "_busy"}, busy_o, 0);
  endtask

  task automatic wait_strobes(input int n);
    int k = 0;
    while (nstrb < n && k < 2000) begin @(negedge clk); k++; end
    chk("strobe_wait", nstrb >= n, 1);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_addr"}, addr_o, 0);
    chk({nm, "_en"}, enable_read_memory_o, 0);
    chk({nm, "_data"}, uart_data_o, 0);
    chk({nm, "_strb"}, data_valid_strb_o, 0);
    chk({nm, "_busy"}, busy_o, 0);
    chk({nm, "_done"}, done_strb_o, 0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 4'(i);
    #1 chk_zero("reset");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Basic dump with pinned literal bytes.
    tx_b = 20;
    start_dump(1);
    wait_done("basic");
    chk("basic_first", got[0], 8'h01);
    chk("basic_mid", got[5], 8'hAB);
    chk("basic_last", got[7], 8'hEF);
`ifdef DUMPER_CHECKSUM_EN
    chk("basic_csum", got[8], 8'h00);
`endif

    // Randomised images and transmitter speeds; one run gets a stray start mid-dump.
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 16; i++) mem[i] = 4'($urandom_range(0, 15));
      tx_b = $urandom_range(1, 12);
      start_dump(1);
      if (r == 1) begin
        wait_strobes(2);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      wait_done("rand");
    end

    // Transmitter held busy at the first SEND.
    for (int i = 0; i < 16; i++) mem[i] = 4'(i);
    tx_b = 5;
    hold = 1'b1;
    start_dump(0);
    repeat (5) @(negedge clk);
    for (int i = 0; i < 45; i++) begin
      chk("hs_data", uart_data_o, 8'h01);
      chk("hs_nostrb", nstrb, 0);
      @(negedge clk);
    end
    hold = 1'b0;
    wait_done("handshake");
    chk("hs_first", got[0], 8'h01);

    // Start coinciding with DONE must not launch a new dump.
    tx_b = 3;
    start_dump(1);
    begin
      int k = 0;
      while (!done_strb_o && k < 1000) begin @(negedge clk); k++; end
      chk("done_seen", done_strb_o, 1);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    chk("done_start_busy", busy_o, 0);
    chk("done_start_count", ndone, 1);

    // Asynchronous reset mid-dump, then a clean restart.
    tx_b = 20;
    start_dump(1);
    wait_strobes(3);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk_zero("midreset");
    exp_q.delete();
    timed = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    start_dump(1);
    wait_done("restart");
    chk("restart_first", got[0], 8'h01);

    // Alternating 0xD/0x2 image.
    for (int i = 0; i < 16; i++) mem[i] = (i % 2 == 0) ? 4'hD : 4'h2;
    tx_b = 4;
    start_dump(1);
    wait_done("alt");
    chk("alt_byte0", got[0], 8'hD2);
    chk("alt_byte7", got[7], 8'hD2);
`ifdef DUMPER_CHECKSUM_EN
    chk("alt_csum", got[8], 8'h00);
`endif

    // All 0xF except word 0.
    for (int i = 0; i < 16; i++) mem[i] = 4'hF;
    mem[0] = 4'hE;
    start_dump(1);
    wait_done("allf");
    chk("allf_byte0", got[0], 8'hEF);
    chk("allf_byte1", got[1], 8'hFF);
`ifdef DUMPER_CHECKSUM_EN
    chk("allf_csum", got[8], 8'h10);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
